// File: rtl/load_store_unit.sv
// Load/store unit: turns core byte/half/word requests into word-level memory
// accesses, with lane select, sign/zero extension, read-modify-write for
// sub-word stores, and alignment and range checking.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             core request (valid/ready, we, size, signed, addr, wdata)
//   resp_*            core response (valid/ready, rdata, err)
//   mem_addr          word index driven to the memory
//   mem_wdata         full word to write
//   mem_we            single-cycle write strobe
//   mem_rdata         combinational read data for mem_addr
module load_store_unit #(
   parameter int MEM_DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RESP
   } state_t;

   localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [1:0]  lane_q, lane_d;
   logic [15:0] wdata_q, wdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic [31:0] word_idx;
   logic        req_bad;
   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_val;
   logic [31:0] merged;

   // Request check is done on the live inputs in the accepting cycle.
   always_comb begin
      word_idx = {2'b00, req_addr[31:2]};
      req_bad  = 1'b0;
      case (req_size)
         2'b00:   req_bad = 1'b0;
         2'b01:   req_bad = req_addr[0];
         2'b10:   req_bad = (req_addr[1:0] != 2'b00);
         default: req_bad = 1'b1;
      endcase
      if (word_idx >= DEPTH_W) begin
         req_bad = 1'b1;
      end
   end

   // Lane extraction and merge on the word read in RD.
   always_comb begin
      shifted = mem_rdata >> {lane_q, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size_q)
         2'b00: begin
            load_val = sgn_q ? {{24{byte_v[7]}}, byte_v}
                             : {24'h0, byte_v};
         end
         2'b01: begin
            load_val = sgn_q ? {{16{half_v[15]}}, half_v}
                             : {16'h0, half_v};
         end
         default: load_val = mem_rdata;
      endcase
      merged = mem_rdata;
      if (size_q == 2'b00) begin
         merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      sgn_d        = sgn_q;
      lane_d       = lane_q;
      wdata_d      = wdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d         = req_we;
               size_d       = req_size;
               sgn_d        = req_signed;
               lane_d       = req_addr[1:0];
               wdata_d      = req_wdata[15:0];
               mem_addr_d   = word_idx;
               resp_rdata_d = 32'h0;
               resp_err_d   = req_bad;
               if (req_bad) begin
                  state_d = S_RESP;
               end else if (req_we && req_size == 2'b10) begin
                  mem_wdata_d = req_wdata;
                  state_d     = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            if (we_q) begin
               mem_wdata_d = merged;
               state_d     = S_WR;
            end else begin
               resp_rdata_d = load_val;
               state_d      = S_RESP;
            end
         end
         S_WR: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         sgn_q        <= 1'b0;
         lane_q       <= 2'b00;
         wdata_q      <= 16'h0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         sgn_q        <= sgn_d;
         lane_q       <= lane_d;
         wdata_q      <= wdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Decoded straight from state so async reset drops them at once.
   assign req_ready  = (state_q == S_IDLE) && rst_n;
   assign resp_valid = (state_q == S_RESP);
   assign mem_we     = (state_q == S_WR);
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table of directed requests against a
// behavioural word memory, plus backpressure and async-reset sequences.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:1023];

   int total;
   int bad;

   load_store_unit #(.MEM_DEPTH(1024)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_we && mem_addr < 32'd1024) begin
         mem[mem_addr[9:0]] <= mem_wdata;
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_wes;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs [0:19];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr,
                               input logic [31:0] wdata,
                               input logic [31:0] er, input logic ee,
                               input int lat, input int wes,
                               input logic [31:0] ew);
      vec_t v;
      v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
      v.wdata = wdata; v.exp_rdata = er; v.exp_err = ee;
      v.exp_lat = lat; v.exp_wes = wes; v.exp_wdata = ew;
      return v;
   endfunction

   // Called just after a rising edge; returns just after the edge that
   // completes the response (resp_ready held high).
   task automatic do_req(input vec_t v, input int idx);
      int lat;
      int wes;
      int we_cyc;
      logic [31:0] wd;
      logic [31:0] wa;
      logic [31:0] rd;
      logic        er;
      string nm;
      lat = 0; wes = 0; we_cyc = 0; wd = 0; wa = 0; rd = 0; er = 0;
      req_valid  = 1'b1;
      req_we     = v.we;
      req_size   = v.size;
      req_signed = v.sgn;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      resp_ready = 1'b1;
      @(negedge clk);
      nm = $sformatf("v%0d req_ready", idx);
      chk(nm, 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mem_we) begin
            wes++;
            we_cyc = k;
            wd = mem_wdata;
            wa = mem_addr;
         end
         if (resp_valid) begin
            lat = k;
            rd = resp_rdata;
            er = resp_err;
            break;
         end
      end
      nm = $sformatf("v%0d latency", idx);
      chk(nm, 32'(lat), 32'(v.exp_lat));
      nm = $sformatf("v%0d rdata", idx);
      chk(nm, rd, v.exp_rdata);
      nm = $sformatf("v%0d err", idx);
      chk(nm, 32'(er), 32'(v.exp_err));
      nm = $sformatf("v%0d we_count", idx);
      chk(nm, 32'(wes), 32'(v.exp_wes));
      if (v.exp_wes == 1) begin
         nm = $sformatf("v%0d we_cycle", idx);
         chk(nm, 32'(we_cyc), 32'(v.exp_lat - 1));
         nm = $sformatf("v%0d mem_wdata", idx);
         chk(nm, wd, v.exp_wdata);
         nm = $sformatf("v%0d mem_addr", idx);
         chk(nm, wa, {2'b00, v.addr[31:2]});
      end
      if (lat != 0) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [31:0] held;

   initial begin
      total = 0;
      bad = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_size = 2'b00;
      req_signed = 1'b0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      resp_ready = 1'b0;

      //        we    sz     sg    addr         wdata         rdata         err lat wes wdata
      vecs[0]  = mk(1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF);
      vecs[1]  = mk(0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0);
      vecs[2]  = mk(1, 2'b10, 0, 32'h10,   32'h80FF7F01, 32'h0,        0, 2, 1, 32'h80FF7F01);
      vecs[3]  = mk(0, 2'b00, 1, 32'h12,   32'h0,        32'hFFFFFFFF, 0, 2, 0, 32'h0);
      vecs[4]  = mk(0, 2'b00, 0, 32'h13,   32'h0,        32'h00000080, 0, 2, 0, 32'h0);
      vecs[5]  = mk(0, 2'b00, 1, 32'h10,   32'h0,        32'h00000001, 0, 2, 0, 32'h0);
      vecs[6]  = mk(0, 2'b01, 1, 32'h12,   32'h0,        32'hFFFF80FF, 0, 2, 0, 32'h0);
      vecs[7]  = mk(0, 2'b01, 0, 32'h10,   32'h0,        32'h00007F01, 0, 2, 0, 32'h0);
      vecs[8]  = mk(1, 2'b10, 0, 32'h10,   32'h11223344, 32'h0,        0, 2, 1, 32'h11223344);
      vecs[9]  = mk(1, 2'b01, 0, 32'h12,   32'h9999ABCD, 32'h0,        0, 3, 1, 32'hABCD3344);
      vecs[10] = mk(1, 2'b00, 0, 32'h11,   32'h1234565A, 32'h0,        0, 3, 1, 32'hABCD5A44);
      vecs[11] = mk(0, 2'b10, 0, 32'h10,   32'h0,        32'hABCD5A44, 0, 2, 0, 32'h0);
      vecs[12] = mk(0, 2'b01, 0, 32'h11,   32'h0,        32'h0,        1, 1, 0, 32'h0);
      vecs[13] = mk(1, 2'b10, 0, 32'h12,   32'h55555555, 32'h0,        1, 1, 0, 32'h0);
      vecs[14] = mk(0, 2'b11, 0, 32'h10,   32'h0,        32'h0,        1, 1, 0, 32'h0);
      vecs[15] = mk(0, 2'b10, 0, 32'h1000, 32'h0,        32'h0,        1, 1, 0, 32'h0);
      vecs[16] = mk(1, 2'b00, 0, 32'h1003, 32'h000000EE, 32'h0,        1, 1, 0, 32'h0);
      vecs[17] = mk(0, 2'b10, 0, 32'h10,   32'h0,        32'hABCD5A44, 0, 2, 0, 32'h0);
      vecs[18] = mk(1, 2'b10, 0, 32'hFFC,  32'h12345678, 32'h0,        0, 2, 1, 32'h12345678);
      vecs[19] = mk(0, 2'b00, 1, 32'hFFF,  32'h0,        32'h00000012, 0, 2, 0, 32'h0);

      #2;
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst resp_err", 32'(resp_err), 32'd0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      #10;
      rst_n = 1'b1;
      #1;
      chk("rel req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 20; i++) begin
         do_req(vecs[i], i);
      end
      chk("mem[1024-1]", mem[1023], 32'h12345678);

      // Backpressure: response held for 5 cycles, new requests ignored.
      req_valid = 1'b1;
      req_we = 1'b0;
      req_size = 2'b10;
      req_signed = 1'b0;
      req_addr = 32'h10;
      resp_ready = 1'b0;
      @(posedge clk);
      #1;
      req_we = 1'b1;
      req_wdata = 32'h0;
      @(negedge clk);
      @(negedge clk);
      chk("bp first valid", 32'(resp_valid), 32'd1);
      held = resp_rdata;
      chk("bp rdata", held, 32'hABCD5A44);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("bp%0d valid", c), 32'(resp_valid), 32'd1);
         chk($sformatf("bp%0d rdata", c), resp_rdata, held);
         chk($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
         chk($sformatf("bp%0d mem_we", c), 32'(mem_we), 32'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("bp done valid", 32'(resp_valid), 32'd0);
      chk("bp done req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      do_req(vecs[17], 20);

      // Async reset during WR of a byte store.
      req_valid = 1'b1;
      req_we = 1'b1;
      req_size = 2'b00;
      req_addr = 32'h10;
      req_wdata = 32'h77;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("ar in WR mem_we", 32'(mem_we), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar mem_we", 32'(mem_we), 32'd0);
      chk("ar resp_valid", 32'(resp_valid), 32'd0);
      chk("ar req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("ar rel req_ready", 32'(req_ready), 32'd1);
      chk("ar rel resp_valid", 32'(resp_valid), 32'd0);
      chk("ar rel mem_addr", mem_addr, 32'h0);
      chk("ar rel mem_wdata", mem_wdata, 32'h0);
      @(posedge clk);
      #1;
      do_req(vecs[17], 21);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
